// File: rtl/prescaled_updown_counter_if.sv
// Control and count bus for prescaled_updown_counter.
interface prescaled_updown_counter_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned CNT_W = 4 * DIGITS;

  logic             en;
  logic             up_dn;
  logic             bcd;
  logic             load;
  logic [CNT_W-1:0] load_val;
  logic [CNT_W-1:0] q;
  logic             tick;
  logic             rc;

  // Controller side: drives controls, observes count.
  modport master (
    output en, up_dn, bcd, load, load_val,
    input  q, tick, rc
  );

  // Counter side.
  modport slave (
    input  en, up_dn, bcd, load, load_val,
    output q, tick, rc
  );
endinterface

// File: rtl/prescaled_updown_counter.sv
// Multi-digit hex/BCD up/down counter with clock-enable prescaler,
// synchronous parallel load and registered tick / ripple-carry pulses.
module prescaled_updown_counter #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 50000000,
  parameter int unsigned DIV_W  = 26
) (
  input logic                        clk,
  input logic                        rst_n,
  prescaled_updown_counter_if.slave  bus
);

  localparam int unsigned CNT_W = 4 * DIGITS;
  localparam logic [DIV_W-1:0] PSC_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] q_q, q_d;
  logic             tick_q, tick_d;
  logic             rc_q, rc_d;

  logic [CNT_W-1:0] cnt_next;
  logic             cnt_wrap;

  // Next count value: digit-serial carry/borrow chain starting at digit 0.
  always_comb begin
    logic       carry;
    logic [3:0] dig;
    logic [3:0] dig_n;
    cnt_next = q_q;
    carry    = 1'b1;
    dig      = 4'h0;
    dig_n    = 4'h0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig   = q_q[4*i +: 4];
      dig_n = dig;
      if (carry) begin
        if (bus.up_dn) begin
          // Up: terminal digit (or any invalid BCD digit) wraps and carries.
          if (bus.bcd ? (dig >= 4'd9) : (dig == 4'hF)) begin
            dig_n = 4'h0;
          end else begin
            dig_n = dig + 4'd1;
            carry = 1'b0;
          end
        end else begin
          // Down: zero wraps to terminal and borrows; invalid BCD snaps to 9.
          if (dig == 4'h0) begin
            dig_n = bus.bcd ? 4'd9 : 4'hF;
          end else if (bus.bcd && (dig > 4'd9)) begin
            dig_n = 4'd9;
            carry = 1'b0;
          end else begin
            dig_n = dig - 4'd1;
            carry = 1'b0;
          end
        end
      end
      cnt_next[4*i +: 4] = dig_n;
    end
    cnt_wrap = carry;
  end

  // Load / prescale / tick selection for the next register state.
  always_comb begin
    psc_d  = psc_q;
    q_d    = q_q;
    tick_d = 1'b0;
    rc_d   = 1'b0;
    if (bus.load) begin
      q_d   = bus.load_val;
      psc_d = '0;
    end else if (bus.en) begin
      if (psc_q == PSC_LAST) begin
        psc_d  = '0;
        q_d    = cnt_next;
        tick_d = 1'b1;
        rc_d   = cnt_wrap;
      end else begin
        psc_d = psc_q + DIV_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      psc_q  <= '0;
      q_q    <= '0;
      tick_q <= 1'b0;
      rc_q   <= 1'b0;
    end else begin
      psc_q  <= psc_d;
      q_q    <= q_d;
      tick_q <= tick_d;
      rc_q   <= rc_d;
    end
  end

  assign bus.q    = q_q;
  assign bus.tick = tick_q;
  assign bus.rc   = rc_q;

endmodule

// File: tb/tb_prescaled_updown_counter.sv
// Directed bench: DIGITS=2 with DIV=4 (instance a) and DIV=1 (instance b).
module tb_prescaled_updown_counter;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  logic [9:0] obs;
  logic [9:0] exp_v;

  prescaled_updown_counter_if #(.DIGITS(2)) bus_a ();
  prescaled_updown_counter_if #(.DIGITS(2)) bus_b ();

  prescaled_updown_counter #(.DIGITS(2), .DIV(4), .DIV_W(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  prescaled_updown_counter #(.DIGITS(2), .DIV(1), .DIV_W(1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n clock edges; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_a(input logic [7:0] v);
    bus_a.load = 1'b1; bus_a.load_val = v;
    step(1);
    bus_a.load = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus_a.en = 1'b0; bus_a.up_dn = 1'b1; bus_a.bcd = 1'b0; bus_a.load = 1'b0; bus_a.load_val = 8'h00;
    bus_b.en = 1'b0; bus_b.up_dn = 1'b1; bus_b.bcd = 1'b0; bus_b.load = 1'b0; bus_b.load_val = 8'h00;
    step(3);
    rst_n = 1'b1;
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== 10'h000) begin errors++; $display("FAIL reset_a got=%h exp=%h", obs, 10'h000); end
    obs = {bus_b.q, bus_b.tick, bus_b.rc}; checks++;
    if (obs !== 10'h000) begin errors++; $display("FAIL reset_b got=%h exp=%h", obs, 10'h000); end
  endtask

  task automatic test_hex_up;
    bus_a.en = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      for (int c = 0; c < 3; c++) begin
        step(1);
        obs = {bus_a.q, bus_a.tick, bus_a.rc}; exp_v = {8'(k - 1), 2'b00}; checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL hex_up_idle k=%0d got=%h exp=%h", k, obs, exp_v); end
      end
      step(1);
      obs = {bus_a.q, bus_a.tick, bus_a.rc}; exp_v = {8'(k), 2'b10}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL hex_up_tick k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
  endtask

  task automatic test_hex_wrap;
    load_a(8'hFE);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'hFE, 2'b00}) begin errors++; $display("FAIL hex_load got=%h exp=%h", obs, {8'hFE, 2'b00}); end
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'hFF, 2'b10}) begin errors++; $display("FAIL hex_ff got=%h exp=%h", obs, {8'hFF, 2'b10}); end
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h00, 2'b11}) begin errors++; $display("FAIL hex_wrap got=%h exp=%h", obs, {8'h00, 2'b11}); end
    step(1);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h00, 2'b00}) begin errors++; $display("FAIL hex_rc_one_cycle got=%h exp=%h", obs, {8'h00, 2'b00}); end
  endtask

  task automatic test_bcd_wrap;
    bus_a.bcd = 1'b1; bus_a.up_dn = 1'b1;
    load_a(8'h98);
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h99, 2'b10}) begin errors++; $display("FAIL bcd_99 got=%h exp=%h", obs, {8'h99, 2'b10}); end
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h00, 2'b11}) begin errors++; $display("FAIL bcd_up_wrap got=%h exp=%h", obs, {8'h00, 2'b11}); end
    bus_a.up_dn = 1'b0;
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h99, 2'b11}) begin errors++; $display("FAIL bcd_dn_wrap got=%h exp=%h", obs, {8'h99, 2'b11}); end
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h98, 2'b10}) begin errors++; $display("FAIL bcd_98 got=%h exp=%h", obs, {8'h98, 2'b10}); end
  endtask

  task automatic test_bcd_invalid;
    bus_a.bcd = 1'b1; bus_a.up_dn = 1'b1;
    load_a(8'h0C);
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h10, 2'b10}) begin errors++; $display("FAIL bcd_inv_up got=%h exp=%h", obs, {8'h10, 2'b10}); end
    bus_a.up_dn = 1'b0;
    load_a(8'h0C);
    step(4);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h09, 2'b10}) begin errors++; $display("FAIL bcd_inv_dn got=%h exp=%h", obs, {8'h09, 2'b10}); end
  endtask

  task automatic test_enable_freeze;
    bus_a.bcd = 1'b0; bus_a.up_dn = 1'b1;
    load_a(8'h00);
    step(2);
    bus_a.en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      step(1);
      obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
      if (obs !== {8'h00, 2'b00}) begin errors++; $display("FAIL freeze c=%0d got=%h exp=%h", c, obs, {8'h00, 2'b00}); end
    end
    bus_a.en = 1'b1;
    step(1);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h00, 2'b00}) begin errors++; $display("FAIL resume_wait got=%h exp=%h", obs, {8'h00, 2'b00}); end
    step(1);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h01, 2'b10}) begin errors++; $display("FAIL resume_tick got=%h exp=%h", obs, {8'h01, 2'b10}); end
  endtask

  task automatic test_load_vs_tick;
    load_a(8'h00);
    step(3);
    load_a(8'h55);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h55, 2'b00}) begin errors++; $display("FAIL load_wins got=%h exp=%h", obs, {8'h55, 2'b00}); end
    step(3);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h55, 2'b00}) begin errors++; $display("FAIL load_psc_clr got=%h exp=%h", obs, {8'h55, 2'b00}); end
    step(1);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h56, 2'b10}) begin errors++; $display("FAIL load_next_tick got=%h exp=%h", obs, {8'h56, 2'b10}); end
  endtask

  task automatic test_reset_vs_load;
    step(2);
    rst_n = 1'b0; bus_a.load = 1'b1; bus_a.load_val = 8'hAA;
    step(1);
    rst_n = 1'b1; bus_a.load = 1'b0;
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h00, 2'b00}) begin errors++; $display("FAIL reset_over_load got=%h exp=%h", obs, {8'h00, 2'b00}); end
    step(3);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h00, 2'b00}) begin errors++; $display("FAIL reset_psc_clr got=%h exp=%h", obs, {8'h00, 2'b00}); end
    step(1);
    obs = {bus_a.q, bus_a.tick, bus_a.rc}; checks++;
    if (obs !== {8'h01, 2'b10}) begin errors++; $display("FAIL reset_first_tick got=%h exp=%h", obs, {8'h01, 2'b10}); end
  endtask

  task automatic test_div1;
    bus_b.en = 1'b1; bus_b.up_dn = 1'b1; bus_b.bcd = 1'b1;
    bus_b.load = 1'b1; bus_b.load_val = 8'h09;
    step(1);
    bus_b.load = 1'b0;
    obs = {bus_b.q, bus_b.tick, bus_b.rc}; checks++;
    if (obs !== {8'h09, 2'b00}) begin errors++; $display("FAIL div1_load got=%h exp=%h", obs, {8'h09, 2'b00}); end
    for (int k = 0; k < 3; k++) begin
      step(1);
      obs = {bus_b.q, bus_b.tick, bus_b.rc}; exp_v = {8'h10 + 8'(k), 2'b10}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL div1_bcd k=%0d got=%h exp=%h", k, obs, exp_v); end
    end
    bus_b.bcd = 1'b0; bus_b.up_dn = 1'b0;
    bus_b.load = 1'b1; bus_b.load_val = 8'h00;
    step(1);
    bus_b.load = 1'b0;
    step(1);
    obs = {bus_b.q, bus_b.tick, bus_b.rc}; checks++;
    if (obs !== {8'hFF, 2'b11}) begin errors++; $display("FAIL div1_hex_dn_wrap got=%h exp=%h", obs, {8'hFF, 2'b11}); end
    step(1);
    obs = {bus_b.q, bus_b.tick, bus_b.rc}; checks++;
    if (obs !== {8'hFE, 2'b10}) begin errors++; $display("FAIL div1_hex_dn got=%h exp=%h", obs, {8'hFE, 2'b10}); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset;
    test_hex_up;
    test_hex_wrap;
    test_bcd_wrap;
    test_bcd_invalid;
    test_enable_freeze;
    test_load_vs_tick;
    test_reset_vs_load;
    test_div1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prescaled_updown_counter.md
Name: prescaled_updown_counter

Overview:
- Parametrised multi-digit up/down counter with built-in clock-enable prescaler, selectable hex or BCD digit arithmetic, synchronous parallel load and a registered ripple-carry pulse.
- Generalises the fixed 4-bit counter driven by a separate 1 s divider. Drives the 7-segment display path with a packed nibble vector; `rc` lights a status LED or chains to another counter.
- Everything runs on one system clock. There are no derived clocks.

Parameters:
- `DIGITS`, 4: number of 4-bit digits. Count width is 4*DIGITS.
- `DIV`, 50000000: prescaler period in clk cycles per count tick. Must be >= 1.
- `DIV_W`, 26: prescaler register width. Must satisfy 2^DIV_W >= DIV.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  synchronous active-low reset.
- `en`  in  1  count enable. 0 freezes the prescaler and the count.
- `up_dn`  in  1  direction: 1 = up, 0 = down. Sampled on the tick cycle.
- `bcd`  in  1  arithmetic mode: 1 = BCD (digits 0-9), 0 = hex (digits 0-F). Sampled on the tick cycle.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  4*DIGITS  value loaded when `load` = 1.
- `q`  out  4*DIGITS  current count. Digit 0 is `q[3:0]` (least significant).
- `tick`  out  1  one-cycle pulse, high on each cycle the count advances.
- `rc`  out  1  one-cycle ripple-carry/borrow pulse on wrap-around.

Behaviour:
- Reset (`rst_n` = 0 at a clk edge):
  - `q` = 0, prescaler = 0, `tick` = 0, `rc` = 0.
  - Reset overrides `load` and `en`.
- Priority per cycle: reset > `load` > count tick.
- Load (`load` = 1):
  - `q` <= `load_val` next cycle.
  - Prescaler <= 0.
  - `tick` = 0 and `rc` = 0 on that cycle.
  - Load works regardless of `en`.
- Prescaler:
  - When `en` = 1 and not loading: `psc` increments. At `psc` = DIV-1, the next value is 0 and an internal tick fires.
  - When `en` = 0: `psc` holds, no tick.
  - With DIV = 1 a tick fires on every enabled cycle.
- Tick cycle:
  - `q` is updated at the same clk edge that registers `tick` = 1.
  - The `tick` output is registered, so it is high for exactly the one cycle in which the new `q` first appears.
- Up arithmetic:
  - Digit 0 increments. Each digit carries into the next when it reaches its terminal value.
  - Terminal value: F in hex mode; 9 in BCD mode. A BCD digit >= 9 (including invalid A-F from a load) goes to 0 and carries.
- Down arithmetic:
  - A digit at 0 becomes F (hex) or 9 (BCD) and borrows.
  - In BCD mode an invalid digit (>9) becomes 9 with no borrow.
  - Otherwise the digit decrements with no borrow.
- Ripple carry:
  - `rc` = 1 for the one cycle coinciding with `tick` when the most significant digit carries (up) or borrows (down).
  - Up wrap: all-F → 0 in hex; 99..9 → 0 in BCD.
  - Down wrap: 0 → all-F or 99..9.
  - Otherwise `rc` = 0.
- Mode/direction changes:
  - Take effect on the next tick.
  - No conversion of the stored value.
- Outputs hold between ticks. `tick` and `rc` are 0 on every non-tick cycle.
- Reset mid-prescale discards the partial prescale count.

Test Plan (DIGITS = 2, DIV = 4 unless stated):
1. Reset, then `en` = 1, `up_dn` = 1, `bcd` = 0 → `tick` every 4th cycle; `q` = 01, 02, ... 0F, 10; `rc` = 0; first tick 4 cycles after `en` rises.
2. Load FE, hex, up → `q` = FF, then 00 with `rc` = 1 for exactly that cycle; load cycle shows `tick` = 0, `rc` = 0.
3. `bcd` = 1, load 98, up → `q` = 99, then 00 with `rc` = 1. Then `up_dn` = 0 → `q` = 99 with `rc` = 1, then 98.
4. `bcd` = 1, load 0C, up → 10 (invalid digit wraps with carry). Load 0C, down → 09, no `rc`.
5. Counting, drop `en` for 10 cycles mid-prescale → `q`, `psc`, `tick` frozen; on re-enable the remaining prescale cycles complete before the next tick.
6. `load` and internal tick in the same cycle → `q` = `load_val`, `tick` = 0. `rst_n` = 0 together with `load` = 1 → `q` = 0. DIV = 1 → `q` advances every enabled cycle.
